if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 115 +++++++++++
 tb/tb_if_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, instruction memory request and IF/ID register.
// Optional redirect counter output enabled by defining IF_STAGE_REDIRECT_CNT_EN.
module if_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        pc_write,
  input  logic        halt,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] if_instr,
  output logic [3:0]  if_opcode,
  output logic [15:0] if_pc,
  output logic        if_valid,
  output logic        halted
`ifdef IF_STAGE_REDIRECT_CNT_EN
  ,
  output logic [15:0] redirect_cnt
`endif
);

  localparam int unsigned XLEN = 16;

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HALT  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            valid_q, valid_d;

  // Request only when nothing overrides fetch and the IF/ID slot can accept a word.
  assign imem_req  = (state_q == FETCH) && !redirect && !halt && (pc_write || !valid_q);
  assign imem_addr = pc_q;
  assign if_instr  = instr_q;
  assign if_opcode = instr_q[15:12];
  assign if_pc     = ipc_q;
  assign if_valid  = valid_q;
  assign halted    = (state_q == HALT);

`ifdef IF_STAGE_REDIRECT_CNT_EN
  logic [XLEN-1:0] cnt_q, cnt_d;
  assign redirect_cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == FETCH) && redirect && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Next-state: redirect beats halt, halt beats stall/fetch; HALT is terminal until reset.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (halt) begin
          valid_d = 1'b0;
          state_d = HALT;
        end else if (imem_req) begin
          if (imem_ready) begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + XLEN'(1);
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall, redirect, wait states, wrap, halt and reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic        pc_write;
  logic        halt;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] if_instr;
  logic [3:0]  if_opcode;
  logic [15:0] if_pc;
  logic        if_valid;
  logic        halted;
`ifdef IF_STAGE_REDIRECT_CNT_EN
  logic [15:0] redirect_cnt;
`endif

  logic        ovr_en;
  logic [15:0] ovr_val;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  // Memory model: returns a fixed override or addr ^ 16'hA5A5.
  assign imem_rdata = ovr_en ? ovr_val : (imem_addr ^ 16'hA5A5);

  if_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .pc_write    (pc_write),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_instr    (if_instr),
    .if_opcode   (if_opcode),
    .if_pc       (if_pc),
    .if_valid    (if_valid),
    .halted      (halted)
`ifdef IF_STAGE_REDIRECT_CNT_EN
    ,
    .redirect_cnt(redirect_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; pc_write = 1'b1; halt = 1'b0;
    redirect = 1'b0; redirect_pc = 16'h0000; ovr_en = 1'b0; ovr_val = 16'h0000;
    #1;
    chk("rst_valid",  32'(if_valid),  32'h0);
    chk("rst_halted", 32'(halted),    32'h0);
    chk("rst_addr",   32'(imem_addr), 32'h0000);
    chk("rst_instr",  32'(if_instr),  32'h0000);
    chk("rst_ifpc",   32'(if_pc),     32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_req",  32'(imem_req),  32'h1);

    // Sequential fetch, if_pc lags imem_addr by one.
    cyc();
    chk("seq0_valid", 32'(if_valid),  32'h1);
    chk("seq0_pc",    32'(if_pc),     32'h0000);
    chk("seq0_instr", 32'(if_instr),  32'hA5A5);
    chk("seq0_op",    32'(if_opcode), 32'hA);
    chk("seq0_addr",  32'(imem_addr), 32'h0001);
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk("seq_pc",    32'(if_pc),     32'(i));
      chk("seq_instr", 32'(if_instr),  32'(16'(i) ^ 16'hA5A5));
      chk("seq_addr",  32'(imem_addr), 32'(i + 1));
    end

    // Capture 16'h1234 then stall three cycles.
    ovr_en = 1'b1; ovr_val = 16'h1234;
    cyc();
    chk("cap_instr", 32'(if_instr),  32'h1234);
    chk("cap_pc",    32'(if_pc),     32'h0004);
    ovr_en = 1'b0; pc_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_req", 32'(imem_req), 32'h0);
      cyc();
      chk("stall_instr", 32'(if_instr),  32'h1234);
      chk("stall_ifpc",  32'(if_pc),     32'h0004);
      chk("stall_addr",  32'(imem_addr), 32'h0005);
      chk("stall_valid", 32'(if_valid),  32'h1);
    end
    pc_write = 1'b1;
    #1;
    chk("resume_req", 32'(imem_req), 32'h1);
    cyc();
    chk("resume_pc",    32'(if_pc),     32'h0005);
    chk("resume_instr", 32'(if_instr),  32'hA5A0);
    chk("resume_addr",  32'(imem_addr), 32'h0006);

    // Redirect with a ready response in the same cycle: response dropped.
    redirect = 1'b1; redirect_pc = 16'h0040;
    #1;
    chk("redir_req", 32'(imem_req), 32'h0);
    cyc();
    chk("redir_valid", 32'(if_valid),  32'h0);
    chk("redir_addr",  32'(imem_addr), 32'h0040);
    chk("redir_instr", 32'(if_instr),  32'hA5A0);
    redirect = 1'b0;
    cyc();
    chk("post_redir_pc",    32'(if_pc),    32'h0040);
    chk("post_redir_instr", 32'(if_instr), 32'hA5E5);
    chk("post_redir_valid", 32'(if_valid), 32'h1);

    // Two wait states.
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("wait_valid", 32'(if_valid),  32'h0);
      chk("wait_addr",  32'(imem_addr), 32'h0041);
      chk("wait_instr", 32'(if_instr),  32'hA5E5);
    end
    imem_ready = 1'b1;
    cyc();
    chk("ready_valid", 32'(if_valid),  32'h1);
    chk("ready_pc",    32'(if_pc),     32'h0041);
    chk("ready_instr", 32'(if_instr),  32'hA5E4);
    chk("ready_addr",  32'(imem_addr), 32'h0042);

    // PC wrap from 16'hFFFF.
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    cyc();
    chk("wrap_pre_addr", 32'(imem_addr), 32'hFFFF);
    redirect = 1'b0;
    cyc();
    chk("wrap_pc",    32'(if_pc),     32'hFFFF);
    chk("wrap_instr", 32'(if_instr),  32'h5A5A);
    chk("wrap_addr",  32'(imem_addr), 32'h0000);
    redirect = 1'b1; redirect_pc = 16'h0010;
    cyc();
    chk("redir3_addr", 32'(imem_addr), 32'h0010);
`ifdef IF_STAGE_REDIRECT_CNT_EN
    chk("redirect_cnt", 32'(redirect_cnt), 32'h3);
`endif
    redirect = 1'b0;
    cyc();
    chk("r3_pc",    32'(if_pc),    32'h0010);
    chk("r3_instr", 32'(if_instr), 32'hA5B5);

    // Halt: terminal, redirect ignored.
    halt = 1'b1;
    #1;
    chk("halt_req", 32'(imem_req), 32'h0);
    cyc();
    chk("halt_halted", 32'(halted),    32'h1);
    chk("halt_valid",  32'(if_valid),  32'h0);
    chk("halt_addr",   32'(imem_addr), 32'h0011);
    halt = 1'b0; redirect = 1'b1; redirect_pc = 16'h0080;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("halted_req", 32'(imem_req), 32'h0);
      cyc();
      chk("halted_stay", 32'(halted),    32'h1);
      chk("halted_addr", 32'(imem_addr), 32'h0011);
      chk("halted_vld",  32'(if_valid),  32'h0);
    end
    redirect = 1'b0;

    // Asynchronous reset pulse mid-cycle.
    rst_n = 1'b0;
    #1;
    chk("rst2_addr",   32'(imem_addr), 32'h0000);
    chk("rst2_halted", 32'(halted),    32'h0);
    chk("rst2_valid",  32'(if_valid),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("rst2_pc",    32'(if_pc),     32'h0000);
    chk("rst2_instr", 32'(if_instr),  32'hA5A5);
    chk("rst2_next",  32'(imem_addr), 32'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
